// File: rtl/risc0_muldiv.sv
// Iterative multiply / Euclidean divide unit for the RISC0 core.
// One shift-add or restoring shift-subtract step per cycle through a shared accumulator.
module risc0_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             stall,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz,
  output logic [1:0]       dbg_state
);

  localparam int CNTW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: the core raises run and holds it with stable operands until it
  // sees stall low; lo/hi/dz are valid in that cycle. run must then drop for at
  // least one cycle before the next request is accepted.

  logic [1:0]       state;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] x_r;
  logic             op_r;
  logic             xneg_r;
  logic             yneg_r;

  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic               fix;
  logic               res_neg;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   res_hi;
  logic               res_dz;

  logic accept;
  logic step;
  logic last;

  assign stall     = run & (state != S_DONE);
  assign dbg_state = state;

  assign accept = ~rst & run & (state == S_IDLE);
  assign step   = ~rst & run & (state == S_RUN);
  assign last   = step & (cnt == CNTW'(1));

  always_comb begin
    x_neg = sgn & x[WIDTH-1];
    y_neg = sgn & y[WIDTH-1];
    x_mag = x_neg ? -x : x;
    y_mag = y_neg ? -y : y;
  end

  // The multiplier (x magnitude) shifts out of acc_lo LSB-first while the
  // product grows in from the top; the divide shifts the dividend out MSB-first
  // and the quotient bits in at the bottom.
  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_r};
    div_ge    = ~div_diff[WIDTH+1];
    if (op_r) begin
      step_hi = div_ge ? div_diff[WIDTH:0] : div_shift;
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = {1'b0, mul_sum[WIDTH:1]};
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction on the final step. A negative dividend with a non-zero
  // magnitude remainder moves the remainder to |y|-rm and bumps |q| so r >= 0.
  always_comb begin
    prod    = {step_hi[WIDTH-1:0], step_lo};
    res_neg = xneg_r ^ yneg_r;
    prod_s  = res_neg ? -prod : prod;
    rem_mag = step_hi[WIDTH-1:0];
    fix     = xneg_r & (rem_mag != '0);
    rem_fix = fix ? (b_r - rem_mag) : rem_mag;
    quo_fix = step_lo + {{(WIDTH-1){1'b0}}, fix};
    if (!op_r) begin
      res_lo = prod_s[WIDTH-1:0];
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_dz = 1'b0;
    end else if (b_r == '0) begin
      res_lo = '1;
      res_hi = x_r;
      res_dz = 1'b1;
    end else begin
      res_lo = res_neg ? -quo_fix : quo_fix;
      res_hi = rem_fix;
      res_dz = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      lo    <= '0;
      hi    <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            cnt   <= CNTW'(WIDTH);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!run) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) begin
              lo    <= res_lo;
              hi    <= res_hi;
              dz    <= res_dz;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!run) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; their contents only matter after a latch.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= op;
      xneg_r <= x_neg;
      yneg_r <= y_neg;
      b_r    <= y_mag;
      x_r    <= x;
      acc_hi <= '0;
      acc_lo <= x_mag;
    end else if (step && !last) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

endmodule

// File: tb/tb_risc0_muldiv.sv
// Self-checking bench for risc0_muldiv at WIDTH=32 and WIDTH=8: directed table,
// multi-cycle abort/reset sequences and randomized operations against a model.
module tb_risc0_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        run_a, op_a, sgn_a, stall_a, dz_a;
  logic [31:0] x_a, y_a, lo_a, hi_a;
  logic [1:0]  st_a;

  logic        run_b, op_b, sgn_b, stall_b, dz_b;
  logic [7:0]  x_b, y_b, lo_b, hi_b;
  logic [1:0]  st_b;

  risc0_muldiv #(.WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .run(run_a), .op(op_a), .sgn(sgn_a), .x(x_a), .y(y_a),
    .stall(stall_a), .lo(lo_a), .hi(hi_a), .dz(dz_a), .dbg_state(st_a)
  );

  risc0_muldiv #(.WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .op(op_b), .sgn(sgn_b), .x(x_b), .y(y_b),
    .stall(stall_b), .lo(lo_b), .hi(hi_b), .dz(dz_b), .dbg_state(st_b)
  );

  typedef struct {
    logic        op;
    logic        sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  vec_t tbl[12];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: full-width product, and Euclidean division from its definition.
  function automatic void model(input int w, input logic o, input logic s,
                                input logic [31:0] xb, input logic [31:0] yb,
                                output logic [31:0] elo, output logic [31:0] ehi,
                                output logic edz);
    longint xs, ys, ay, p, q, r;
    logic [63:0] pu, t;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xs = (s && xb[w-1]) ? longint'(xb) - (longint'(1) << w) : longint'(xb);
    ys = (s && yb[w-1]) ? longint'(yb) - (longint'(1) << w) : longint'(yb);
    if (!o) begin
      p   = xs * ys;
      pu  = p;
      t   = pu >> w;
      elo = pu[31:0] & mask;
      ehi = t[31:0] & mask;
      edz = 1'b0;
    end else if (yb == 32'd0) begin
      elo = mask;
      ehi = xb;
      edz = 1'b1;
    end else begin
      ay = (ys < 0) ? -ys : ys;
      r  = xs % ay;
      if (r < 0) r = r + ay;
      q   = (xs - r) / ys;
      elo = q[31:0] & mask;
      ehi = r[31:0] & mask;
      edz = 1'b0;
    end
  endfunction

  // Issues one request, holds run until stall drops (bounded), returns the
  // number of stall-high cycles and the results, then releases run.
  task automatic do_op(input int w, input logic o, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input bit scramble,
                       output int n, output logic [31:0] rlo, output logic [31:0] rhi,
                       output logic rdz);
    if (w == 32) begin
      op_a = o; sgn_a = s; x_a = a; y_a = b; run_a = 1'b1;
    end else begin
      op_b = o; sgn_b = s; x_b = a[7:0]; y_b = b[7:0]; run_b = 1'b1;
    end
    #1;
    n = 0;
    while (((w == 32) ? stall_a : stall_b) && n < 300) begin
      n++;
      @(posedge clk);
      #1;
      if (scramble) begin
        if (w == 32) begin x_a = $urandom; y_a = $urandom; end
        else begin x_b = 8'($urandom); y_b = 8'($urandom); end
      end
    end
    if (w == 32) begin
      rlo = lo_a; rhi = hi_a; rdz = dz_a; run_a = 1'b0;
    end else begin
      rlo = {24'd0, lo_b}; rhi = {24'd0, hi_b}; rdz = dz_b; run_b = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [31:0] rlo, rhi, elo, ehi, a, b;
    logic rdz, edz, o, s;

    tbl[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFC, 32'h0000_0001, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0004, 32'h0000_0001, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 32'h0000_0000, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

    rst = 1'b1;
    run_a = 1'b0; op_a = 1'b0; sgn_a = 1'b0; x_a = '0; y_a = '0;
    run_b = 1'b0; op_b = 1'b0; sgn_b = 1'b0; x_b = '0; y_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lo", lo_a, 32'd0);
    chk("rst_hi", hi_a, 32'd0);
    chk("rst_dz", {31'd0, dz_a}, 32'd0);
    chk("rst_stall", {31'd0, stall_a}, 32'd0);
    chk("rst_state", {30'd0, st_a}, 32'd0);
    chk("rst_lo8", {24'd0, lo_b}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      do_op(32, tbl[i].op, tbl[i].sgn, tbl[i].x, tbl[i].y, 1'b0, n, rlo, rhi, rdz);
      chk($sformatf("v%0d_stall", i), n, 32'd33);
      chk($sformatf("v%0d_lo", i), rlo, tbl[i].lo);
      chk($sformatf("v%0d_hi", i), rhi, tbl[i].hi);
      chk($sformatf("v%0d_dz", i), {31'd0, rdz}, {31'd0, tbl[i].dz});
    end

    // Narrow instance, operands scrambled after the latch cycle.
    do_op(8, 1'b1, 1'b0, 32'd200, 32'd7, 1'b1, n, rlo, rhi, rdz);
    chk("w8_stall", n, 32'd9);
    chk("w8_lo", rlo, 32'd28);
    chk("w8_hi", rhi, 32'd4);
    do_op(8, 1'b1, 1'b1, 32'h80, 32'hFF, 1'b0, n, rlo, rhi, rdz);
    chk("w8_ovf_lo", rlo, 32'h80);
    chk("w8_ovf_hi", rhi, 32'h00);
    chk("w8_ovf_dz", {31'd0, rdz}, 32'd0);

    // Reset in the middle of a divide with run still high.
    do_op(32, 1'b0, 1'b0, 32'd3, 32'd7, 1'b0, n, rlo, rhi, rdz);
    chk("pre_rst_lo", rlo, 32'h15);
    op_a = 1'b1; sgn_a = 1'b0; x_a = 32'd100; y_a = 32'd7; run_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_stall", {31'd0, stall_a}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_lo", lo_a, 32'd0);
    chk("midrst_hi", hi_a, 32'd0);
    chk("midrst_state", {30'd0, st_a}, 32'd0);
    chk("midrst_stall", {31'd0, stall_a}, 32'd1);
    n = 0;
    while (stall_a && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("restart_stall", n, 32'd33);
    chk("restart_lo", lo_a, 32'd14);
    chk("restart_hi", hi_a, 32'd2);
    run_a = 1'b0;
    @(posedge clk);
    #1;

    // Abort by dropping run in the middle of a divide.
    do_op(32, 1'b0, 1'b0, 32'd3, 32'd7, 1'b0, n, rlo, rhi, rdz);
    op_a = 1'b1; sgn_a = 1'b1; x_a = 32'hFFFF_FF00; y_a = 32'd0; run_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    run_a = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_state", {30'd0, st_a}, 32'd0);
    chk("abort_lo", lo_a, 32'h15);
    chk("abort_hi", hi_a, 32'd0);
    chk("abort_dz", {31'd0, dz_a}, 32'd0);
    chk("abort_stall", {31'd0, stall_a}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      model(32, o, s, a, b, elo, ehi, edz);
      do_op(32, o, s, a, b, 1'b1, n, rlo, rhi, rdz);
      chk($sformatf("r32_%0d_stall", i), n, 32'd33);
      chk($sformatf("r32_%0d_lo op%0d s%0d x%h y%h", i, o, s, a, b), rlo, elo);
      chk($sformatf("r32_%0d_hi op%0d s%0d x%h y%h", i, o, s, a, b), rhi, ehi);
      chk($sformatf("r32_%0d_dz", i), {31'd0, rdz}, {31'd0, edz});
    end

    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom_range(0, 255);
      model(8, o, s, a, b, elo, ehi, edz);
      do_op(8, o, s, a, b, 1'b1, n, rlo, rhi, rdz);
      chk($sformatf("r8_%0d_stall", i), n, 32'd9);
      chk($sformatf("r8_%0d_lo op%0d s%0d x%h y%h", i, o, s, a, b), rlo, elo);
      chk($sformatf("r8_%0d_hi op%0d s%0d x%h y%h", i, o, s, a, b), rhi, ehi);
      chk($sformatf("r8_%0d_dz", i), {31'd0, rdz}, {31'd0, edz});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
